fetch_unit: RTL and testbench
=============================

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter RESET_PC, 32'h0000_0000, byte address of the first instruction fetched after reset.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 imem_req  output  1  instruction-memory read request, held until acknowledged.
REQ-005 imem_addr  output  32  word-aligned byte address of the request (current PC).
REQ-006 imem_ack  input  1  memory returns imem_rdata in the same cycle; request completes on the edge where imem_req && imem_ack.
REQ-007 imem_rdata  input  32  instruction word, valid only when imem_ack=1.
REQ-008 inst_valid  output  1  inst_out/inst_pc hold an instruction for the decoder.
REQ-009 inst_out  output  32  buffered instruction; inst_out[6:0] drives the decoder opcode input.
REQ-010 inst_pc  output  32  address the buffered instruction was fetched from.
REQ-011 inst_ready  input  1  decoder accepts the buffered instruction.
REQ-012 redirect  input  1  taken branch/JAL/JALR; squash and refetch from redirect_pc.
REQ-013 redirect_pc  input  32  redirect target; bits [1:0] ignored (treated as 00).
REQ-014 halted  output  1  halt instruction (opcode 7'b1111111) has been consumed; fetching stopped.
REQ-015 fetch_count  output  32  number of instructions transferred to the decoder since reset.

Function
REQ-016 States: IDLE, RUN, HALT; state register, PC, one-entry instruction buffer and fetch_count are the only storage.
REQ-017 IDLE: entered by reset; imem_req=0; unconditionally moves to RUN on the next edge.
REQ-018 Transfer to decoder SHALL be defined as inst_valid && inst_ready && !redirect.
REQ-019 RUN: imem_req=1 when (!inst_valid || transfer) && !redirect && buffered opcode is not 7'b1111111 (or buffer empty); otherwise imem_req=0.
REQ-020 imem_addr SHALL equal PC and remain stable while imem_req=1 and imem_ack=0.
REQ-021 On edge with imem_req && imem_ack: buffer <= imem_rdata, inst_pc <= PC, inst_valid <= 1, PC <= PC+4 (mod 2^32, wraps 32'hFFFF_FFFC -> 0).
REQ-022 On transfer without new fill: inst_valid <= 0; with simultaneous fill: buffer replaced, inst_valid stays 1 (throughput one instruction/cycle with zero-wait memory).
REQ-023 Latency: request accepted in cycle N -> inst_valid=1 in cycle N+1.
REQ-024 inst_valid && !inst_ready: buffer, inst_pc, inst_valid hold; imem_req=0.
REQ-025 redirect=1 (any state but HALT/IDLE): imem_req=0 that cycle, any imem_ack ignored; next edge PC <= {redirect_pc[31:2],2'b00}, inst_valid <= 0, no transfer, fetch_count unchanged.
REQ-026 Transfer with inst_out[6:0]==7'b1111111: state <= HALT, inst_valid <= 0, fetch_count increments.
REQ-027 Redirect coincident with a buffered halt SHALL squash it (no HALT entry), per REQ-018/REQ-025.
REQ-028 HALT: imem_req=0, inst_valid=0, halted=1, PC and fetch_count frozen; inputs ignored; exit only via reset.
REQ-029 fetch_count increments by 1 per transfer, wraps 32'hFFFF_FFFF -> 0.
REQ-030 inst_valid SHALL never be 1 with inst_out unwritten since reset.

Reset
REQ-031 While reset=1 (asynchronously, mid-transaction included): state=IDLE, PC=RESET_PC, imem_req=0, imem_addr=RESET_PC, inst_valid=0, inst_out=0, inst_pc=0, halted=0, fetch_count=0.
REQ-032 First imem_req SHALL rise one cycle after the first edge following reset deassertion (IDLE->RUN).
REQ-033 Any pending imem_ack during or at release of reset SHALL be discarded.

Verification
REQ-034 Zero-wait memory, inst_ready=1, RESET_PC=0: addresses 0,4,8,C on consecutive cycles; inst_valid continuous from cycle 2; fetch_count=4 after four transfers.
REQ-035 imem_ack delayed 3 cycles at addr 0x10: imem_addr stable at 0x10, imem_req high 4 cycles; inst_valid rises the cycle after ack.
REQ-036 inst_ready=0 for 5 cycles with instruction at 0x8 buffered: imem_req=0, inst_out/inst_pc=0x8 held; resume at 0xC on release.
REQ-037 redirect=1, redirect_pc=0x0000_0103 while buffer valid: next cycle inst_valid=0, imem_addr=0x100; fetch_count unchanged.
REQ-038 Halt word 0x0000_007F at 0x14 accepted: no request to 0x18, halted=1, fetch_count=6; same word with redirect to 0x40 in accept cycle: no halt, fetch resumes at 0x40.
REQ-039 reset asserted mid-wait (imem_req=1, ack=0) then released: outputs per REQ-031 immediately, refetch from RESET_PC, PC wrap test 0xFFFF_FFFC -> 0x0.

Source files
------------

// File: rtl/fetch_unit.sv
// Single-issue instruction fetch: one-entry buffer between instruction memory and decoder,
// with redirect squash and a halt opcode that stops fetching until reset.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        inst_valid,
  output logic [31:0] inst_out,
  output logic [31:0] inst_pc,
  input  logic        inst_ready,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        halted,
  output logic [31:0] fetch_count
);

  typedef enum logic [1:0] {IDLE, RUN, HALT} state_t;
  localparam logic [6:0] HALT_OP = 7'b111_1111;

  state_t      state, state_nxt;
  logic [31:0] pc;
  logic        xfer, fill, buf_halt;

  assign buf_halt  = inst_valid && (inst_out[6:0] == HALT_OP);
  assign xfer      = (state == RUN) && inst_valid && inst_ready && !redirect;
  assign fill      = imem_req && imem_ack;
  assign imem_addr = pc;

  always_ff @(posedge clk or posedge reset)
    if (reset) state <= IDLE;
    else       state <= state_nxt;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    state_nxt = RUN;
      RUN:     if (xfer && buf_halt) state_nxt = HALT;
      default: state_nxt = HALT;
    endcase
  end

  // A buffered halt never lets the next word be requested, consumed or not.
  always_comb begin
    imem_req = 1'b0;
    halted   = 1'b0;
    case (state)
      RUN:     imem_req = (!inst_valid || xfer) && !redirect && !buf_halt;
      HALT:    halted   = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      pc          <= RESET_PC;
      inst_valid  <= 1'b0;
      inst_out    <= '0;
      inst_pc     <= '0;
      fetch_count <= '0;
    end else if (state == RUN) begin
      if (redirect) begin
        pc         <= redirect_pc & ~32'h3;
        inst_valid <= 1'b0;
      end else begin
        if (fill) begin
          inst_out   <= imem_rdata;
          inst_pc    <= pc;
          inst_valid <= 1'b1;
          pc         <= pc + 32'd4;
        end else if (xfer) begin
          inst_valid <= 1'b0;
        end
        if (xfer) fetch_count <= fetch_count + 32'd1;
      end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios plus random traffic against a queue-based
// model of the decoder-visible instruction stream.
module tb_fetch_unit;
  localparam logic [31:0] RPC = 32'h0;

  logic        clk = 1'b0, reset = 1'b1;
  logic        imem_req, inst_valid, halted;
  logic [31:0] imem_addr, inst_out, inst_pc, fetch_count;
  logic        imem_ack = 1'b0, inst_ready = 1'b0, redirect = 1'b0;
  logic [31:0] imem_rdata = '0, redirect_pc = '0;

  int n_vec = 0, n_bad = 0;
  logic [31:0] halt_addr = 32'h1;

  // model: next fetch address, buffered entries, transfer count, run/halt flags
  logic [31:0] m_fpc, m_cnt;
  logic [31:0] q_pc[$], q_in[$];
  bit m_run, m_halt, m_req, m_xfer;
  bit c_ack, c_red;
  logic [31:0] c_rpc;

  fetch_unit #(.RESET_PC(RPC)) dut (
    .clk(clk), .reset(reset), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata), .inst_valid(inst_valid),
    .inst_out(inst_out), .inst_pc(inst_pc), .inst_ready(inst_ready),
    .redirect(redirect), .redirect_pc(redirect_pc), .halted(halted),
    .fetch_count(fetch_count));

  always #5 clk = ~clk;

  function automatic logic [31:0] mem(input logic [31:0] a);
    logic [31:0] w;
    if (a == halt_addr) return 32'h0000_007F;
    w = (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
    if (w[6:0] == 7'h7F) w[0] = 1'b0;
    return w;
  endfunction

  // Called at negedge: drive inputs, let combinational outputs settle, form expectations.
  task automatic apply(input bit a, input bit r, input bit d, input logic [31:0] rp);
    bit hb;
    imem_ack = a; inst_ready = r; redirect = d; redirect_pc = rp;
    imem_rdata = a ? mem(imem_addr) : $urandom();
    c_ack = a; c_red = d; c_rpc = rp;
    #1;
    hb     = q_in.size() != 0 && q_in[0][6:0] == 7'h7F;
    m_xfer = m_run && !m_halt && q_in.size() != 0 && r && !d;
    m_req  = m_run && !m_halt && !d && !hb && (q_in.size() == 0 || r);
  endtask

  task automatic commit();
    @(posedge clk);
    if (!m_run) m_run = 1;
    else if (!m_halt) begin
      if (c_red) begin
        q_pc.delete(); q_in.delete();
        m_fpc = {c_rpc[31:2], 2'b00};
      end else begin
        if (m_xfer) begin
          if (q_in[0][6:0] == 7'h7F) m_halt = 1;
          void'(q_pc.pop_front()); void'(q_in.pop_front());
          m_cnt = m_cnt + 1;
        end
        if (m_req && c_ack) begin
          q_pc.push_back(m_fpc); q_in.push_back(mem(m_fpc));
          m_fpc = m_fpc + 32'd4;
        end
      end
    end
    @(negedge clk);
  endtask

  task automatic reset_assert();
    reset = 1'b1; imem_ack = 1'b1; imem_rdata = 32'h7F; redirect = 1'b0; inst_ready = 1'b1;
    q_pc.delete(); q_in.delete();
    m_fpc = RPC; m_cnt = 0; m_run = 0; m_halt = 0; m_req = 0; m_xfer = 0;
    #1;
  endtask

  task automatic reset_release();
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset_assert();
    n_vec++; if (imem_req !== 1'b0 || inst_valid !== 1'b0 || halted !== 1'b0) begin
      n_bad++; $display("FAIL rst_ctl: req=%b vld=%b halt=%b want 0", imem_req, inst_valid, halted); end
    n_vec++; if (imem_addr !== RPC || inst_out !== 0 || inst_pc !== 0 || fetch_count !== 0) begin
      n_bad++; $display("FAIL rst_data: addr=%h out=%h pc=%h cnt=%0d want %h/0/0/0",
                        imem_addr, inst_out, inst_pc, fetch_count, RPC); end
    reset_release();
    apply(1, 1, 0, 0);
    n_vec++; if (imem_req !== 1'b0) begin n_bad++; $display("FAIL idle_req: got %b want 0", imem_req); end
    commit();
  endtask

  task automatic test_stream();
    for (int i = 0; i < 5; i++) begin
      apply(1, 1, 0, 0);
      n_vec++; if (imem_req !== 1'b1 || imem_addr !== 32'(4 * i)) begin
        n_bad++; $display("FAIL stream_addr: req=%b addr=%h want 1/%h", imem_req, imem_addr, 4 * i); end
      if (i >= 1) begin
        n_vec++; if (inst_valid !== 1'b1 || inst_pc !== 32'(4 * (i - 1)) || inst_out !== mem(4 * (i - 1))) begin
          n_bad++; $display("FAIL stream_inst: vld=%b pc=%h out=%h want 1/%h/%h",
                            inst_valid, inst_pc, inst_out, 4 * (i - 1), mem(4 * (i - 1))); end
      end
      commit();
    end
    n_vec++; if (fetch_count !== 32'd4) begin
      n_bad++; $display("FAIL stream_cnt: got %0d want 4", fetch_count); end
  endtask

  task automatic test_wait();
    apply(0, 1, 1, 32'h10); commit();
    for (int k = 0; k < 4; k++) begin
      apply(k == 3, 1, 0, 0);
      n_vec++; if (imem_req !== 1'b1 || imem_addr !== 32'h10 || inst_valid !== 1'b0) begin
        n_bad++; $display("FAIL wait_hold: req=%b addr=%h vld=%b want 1/10/0", imem_req, imem_addr, inst_valid); end
      commit();
    end
    apply(0, 0, 0, 0);
    n_vec++; if (inst_valid !== 1'b1 || inst_pc !== 32'h10 || inst_out !== mem(32'h10)) begin
      n_bad++; $display("FAIL wait_fill: vld=%b pc=%h out=%h want 1/10/%h", inst_valid, inst_pc, inst_out, mem(32'h10)); end
    commit();
  endtask

  task automatic test_stall();
    apply(0, 1, 1, 32'h8); commit();
    apply(1, 0, 0, 0); commit();
    for (int k = 0; k < 5; k++) begin
      apply(1, 0, 0, 0);
      n_vec++; if (imem_req !== 1'b0 || inst_valid !== 1'b1 || inst_pc !== 32'h8 || inst_out !== mem(32'h8)) begin
        n_bad++; $display("FAIL stall_hold: req=%b vld=%b pc=%h out=%h want 0/1/8/%h",
                          imem_req, inst_valid, inst_pc, inst_out, mem(32'h8)); end
      commit();
    end
    apply(1, 1, 0, 0);
    n_vec++; if (imem_req !== 1'b1 || imem_addr !== 32'hC) begin
      n_bad++; $display("FAIL stall_resume: req=%b addr=%h want 1/c", imem_req, imem_addr); end
    commit();
  endtask

  task automatic test_redirect();
    logic [31:0] fc0;
    fc0 = m_cnt;
    apply(1, 1, 1, 32'h0000_0103);
    n_vec++; if (imem_req !== 1'b0) begin n_bad++; $display("FAIL redir_req: got %b want 0", imem_req); end
    commit();
    apply(0, 0, 0, 0);
    n_vec++; if (inst_valid !== 1'b0 || imem_addr !== 32'h100 || fetch_count !== fc0) begin
      n_bad++; $display("FAIL redir_state: vld=%b addr=%h cnt=%0d want 0/100/%0d",
                        inst_valid, imem_addr, fetch_count, fc0); end
    commit();
  endtask

  task automatic test_wrap();
    apply(0, 1, 1, 32'hFFFF_FFF8); commit();
    for (int i = 0; i < 4; i++) begin
      apply(1, 1, 0, 0);
      n_vec++; if (imem_addr !== 32'(32'hFFFF_FFF8 + 32'(4 * i))) begin
        n_bad++; $display("FAIL wrap_addr: got %h want %h", imem_addr, 32'hFFFF_FFF8 + 32'(4 * i)); end
      commit();
    end
  endtask

  task automatic test_halt();
    halt_addr = 32'h14;
    reset_assert(); reset_release();
    for (int i = 0; i < 12; i++) begin
      apply(1, 1, 0, 0);
      n_vec++; if (imem_req === 1'b1 && imem_addr === 32'h18) begin
        n_bad++; $display("FAIL halt_overfetch: req=%b addr=%h want no request to 18", imem_req, imem_addr); end
      commit();
    end
    for (int i = 0; i < 5; i++) begin
      apply($urandom % 2, $urandom % 2, $urandom % 2, $urandom());
      n_vec++; if (halted !== 1'b1 || fetch_count !== 32'd6 || imem_req !== 1'b0 || inst_valid !== 1'b0) begin
        n_bad++; $display("FAIL halt_state: halt=%b cnt=%0d req=%b vld=%b want 1/6/0/0",
                          halted, fetch_count, imem_req, inst_valid); end
      commit();
    end
  endtask

  task automatic test_halt_squash();
    bit d, seen = 0;
    halt_addr = 32'h14;
    reset_assert(); reset_release();
    for (int i = 0; i < 12; i++) begin
      d = q_pc.size() != 0 && q_pc[0] == 32'h14;
      apply(1, 1, d, 32'h40);
      if (inst_valid === 1'b1 && inst_pc === 32'h40) seen = 1;
      commit();
    end
    n_vec++; if (halted !== 1'b0 || seen !== 1'b1) begin
      n_bad++; $display("FAIL halt_squash: halted=%b seen40=%b want 0/1", halted, seen); end
    halt_addr = 32'h1;
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      apply(($urandom % 4) != 0, ($urandom % 4) != 0, ($urandom % 16) == 0, $urandom());
      n_vec++; if (imem_req !== m_req || imem_addr !== m_fpc) begin
        n_bad++; $display("FAIL rnd_req @%0d: req=%b addr=%h want %b/%h", i, imem_req, imem_addr, m_req, m_fpc); end
      n_vec++; if (inst_valid !== (q_in.size() != 0) ||
                   (q_in.size() != 0 && (inst_out !== q_in[0] || inst_pc !== q_pc[0]))) begin
        n_bad++; $display("FAIL rnd_buf @%0d: vld=%b pc=%h out=%h want %b/%h/%h", i, inst_valid, inst_pc,
                          inst_out, q_in.size() != 0, q_pc.size() ? q_pc[0] : 32'h0, q_in.size() ? q_in[0] : 32'h0); end
      n_vec++; if (fetch_count !== m_cnt || halted !== m_halt) begin
        n_bad++; $display("FAIL rnd_cnt @%0d: cnt=%0d halt=%b want %0d/%b", i, fetch_count, halted, m_cnt, m_halt); end
      commit();
    end
    // reset lands while a request is waiting for its ack
    apply(0, 1, 0, 0);
    n_vec++; if (imem_req !== 1'b1) begin n_bad++; $display("FAIL midwait_req: got %b want 1", imem_req); end
    reset_assert();
    n_vec++; if (imem_req !== 1'b0 || imem_addr !== RPC || inst_valid !== 1'b0 || inst_out !== 0 ||
                 inst_pc !== 0 || fetch_count !== 0 || halted !== 1'b0) begin
      n_bad++; $display("FAIL midwait_rst: req=%b addr=%h vld=%b out=%h pc=%h cnt=%0d halt=%b want reset values",
                        imem_req, imem_addr, inst_valid, inst_out, inst_pc, fetch_count, halted); end
    reset_release();
    apply(1, 1, 0, 0); commit();
    apply(1, 1, 0, 0);
    n_vec++; if (imem_req !== 1'b1 || imem_addr !== RPC) begin
      n_bad++; $display("FAIL refetch: req=%b addr=%h want 1/%h", imem_req, imem_addr, RPC); end
    commit();
    apply(0, 0, 0, 0);
    n_vec++; if (inst_valid !== 1'b1 || inst_pc !== RPC || inst_out !== mem(RPC)) begin
      n_bad++; $display("FAIL refetch_inst: vld=%b pc=%h out=%h want 1/%h/%h", inst_valid, inst_pc, inst_out, RPC, mem(RPC)); end
    commit();
  endtask

  initial begin
    test_reset();
    test_stream();
    test_wait();
    test_stall();
    test_redirect();
    test_wrap();
    test_halt();
    test_halt_squash();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
